// File: rtl/exec_sequencer_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: state codes, trap causes
// and the opcode/funct3 values the sequencer needs to recognise.
package exec_sequencer_pkg;

    localparam logic [2:0] SEQ_FETCH  = 3'd0;
    localparam logic [2:0] SEQ_DECODE = 3'd1;
    localparam logic [2:0] SEQ_EXEC   = 3'd2;
    localparam logic [2:0] SEQ_MEM    = 3'd3;
    localparam logic [2:0] SEQ_WB     = 3'd4;
    localparam logic [2:0] SEQ_HALT   = 3'd5;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_IMEM_TO = 2'd2;
    localparam logic [1:0] TRAP_DMEM_TO = 2'd3;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [2:0] F3_ENV      = 3'b000;

    // FENCE, ECALL and EBREAK retire as plain PC+4 in this core.
    function automatic logic is_nop_op(input logic [6:0] op, input logic [2:0] f3);
        return (op == OP_MISC_MEM) || ((op == OP_SYSTEM) && (f3 == F3_ENV));
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Wait counter for memory handshakes: clears on demand, counts stall cycles and
// flags when MAX_WAIT stalls have elapsed (holds there until cleared).
module seq_wait_timer #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic sat
);

    logic [WAIT_W-1:0] count;

    assign sat = (count == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I core.
// Optional retire counter output instret enabled by EXEC_SEQ_RETIRE_CNT_EN.
//
// state  | meaning
// FETCH  | imem request outstanding, IR latched on ack
// DECODE | legality check of the decoded instruction
// EXEC   | branch/NOP retire here, others dispatch to MEM or WB
// MEM    | data request outstanding until ack
// WB     | register write and PC update
// HALT   | trapped, only reset leaves
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [3:0]  alu_op,
    input  logic        s_load,
    input  logic        s_store,
    input  logic        s_jump,
    input  logic        s_branch,
    input  logic        s_csr,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        rf_we,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef EXEC_SEQ_RETIRE_CNT_EN
    ,
    output logic [63:0] instret
`endif
);

    logic [2:0] state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       jump_q, store_q;
    logic       wait_sat, timer_clear, timer_inc, legal, is_nop;
    logic       imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, pc_sel_c, rf_we_c;

    assign is_nop = is_nop_op(opcode, funct3) && !s_csr;
    assign legal  = s_load | s_store | s_jump | s_branch | s_csr | (alu_op != 4'd0)
                  | is_nop_op(opcode, funct3);

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = 1'b0;
        rf_we_c    = 1'b0;
        case (state_q)
            SEQ_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_we_c = 1'b1;
                    state_d = SEQ_DECODE;
                end else if (wait_sat) begin
                    state_d = SEQ_HALT;
                    cause_d = TRAP_IMEM_TO;
                end
            end
            SEQ_DECODE: begin
                if (legal) begin
                    state_d = SEQ_EXEC;
                end else begin
                    state_d = SEQ_HALT;
                    cause_d = TRAP_ILLEGAL;
                end
            end
            SEQ_EXEC: begin
                if (s_load || s_store) begin
                    state_d = SEQ_MEM;
                end else if (s_branch) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = branch_taken;
                    state_d  = SEQ_FETCH;
                end else if (s_jump) begin
                    state_d = SEQ_WB;
                end else if (is_nop) begin
                    pc_we_c = 1'b1;
                    state_d = SEQ_FETCH;
                end else begin
                    state_d = SEQ_WB;
                end
            end
            SEQ_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = store_q;
                if (dmem_ack) begin
                    if (store_q) begin
                        pc_we_c = 1'b1;
                        state_d = SEQ_FETCH;
                    end else begin
                        state_d = SEQ_WB;
                    end
                end else if (wait_sat) begin
                    state_d = SEQ_HALT;
                    cause_d = TRAP_DMEM_TO;
                end
            end
            SEQ_WB: begin
                rf_we_c  = 1'b1;
                pc_we_c  = 1'b1;
                pc_sel_c = jump_q;
                state_d  = SEQ_FETCH;
            end
            SEQ_HALT: begin
                state_d = SEQ_HALT;
            end
            default: begin
                state_d = SEQ_FETCH;
            end
        endcase
    end

    // Strobes are squashed while reset is high so a late ack cannot write anything.
    assign imem_req   = imem_req_c & ~reset;
    assign dmem_req   = dmem_req_c & ~reset;
    assign dmem_we    = dmem_we_c  & ~reset;
    assign ir_we      = ir_we_c    & ~reset;
    assign pc_we      = pc_we_c    & ~reset;
    assign pc_sel     = pc_sel_c   & ~reset;
    assign rf_we      = rf_we_c    & ~reset;
    assign trap       = (state_q == SEQ_HALT);
    assign trap_cause = cause_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SEQ_FETCH;
            cause_q <= TRAP_NONE;
            jump_q  <= 1'b0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q == SEQ_EXEC) begin
                jump_q  <= s_jump;
                store_q <= s_store;
            end
        end
    end

    assign timer_clear = (state_d != state_q);
    assign timer_inc   = ((state_q == SEQ_FETCH) && !imem_ack) ||
                         ((state_q == SEQ_MEM)   && !dmem_ack);

    seq_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clock (clock),
        .reset (reset),
        .clear (timer_clear),
        .inc   (timer_inc),
        .sat   (wait_sat)
    );

`ifdef EXEC_SEQ_RETIRE_CNT_EN
    // Every pc_we outside HALT returns to FETCH, so it marks one retirement.
    always_ff @(posedge clock) begin
        if (reset) begin
            instret <= 64'd0;
        end else if (pc_we && (state_q != SEQ_HALT)) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized bench for exec_sequencer: per-instruction expected output timelines
// are built from the instruction class and ack delays, and checked every cycle.
module tb_exec_sequencer;

    localparam int MAX_WAIT = 4;
    localparam int C_ALU = 0, C_CSR = 1, C_JUMP = 2, C_BR = 3, C_FENCE = 4,
                   C_ENV = 5, C_LOAD = 6, C_STORE = 7, C_ILL = 8;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_we;
        logic       pc_sel;
        logic       rf_we;
        logic       trap;
        logic [1:0] cause;
    } exp_t;

    logic clock = 1'b0, reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [3:0] alu_op = '0;
    logic s_load = 0, s_store = 0, s_jump = 0, s_branch = 0, s_csr = 0, branch_taken = 0;
    logic imem_ack = 0, dmem_ack = 0;
    logic imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, trap;
    logic [1:0] trap_cause;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
    logic [63:0] instret;
    longint retired = 0;
`endif

    exec_sequencer #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .alu_op(alu_op),
        .s_load(s_load), .s_store(s_store), .s_jump(s_jump), .s_branch(s_branch),
        .s_csr(s_csr), .branch_taken(branch_taken),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        .instret(instret),
`endif
        .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clock = ~clock;

    int   n_cmp = 0, n_fail = 0, cyc_no = 0;
    logic chk_en = 1'b0;
    exp_t exp_v = '0;
    int   n_ir = 0, n_rf = 0, n_dmem = 0, n_dwe = 0, n_pcwe = 0;
    int   last_ir_cyc = 0, last_rf_cyc = 0, last_pcwe_cyc = 0;
    logic last_pcsel = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Per-cycle compare against the expectation the driver published for this cycle.
    initial forever begin
        exp_t got, mask;
        @(negedge clock);
        cyc_no++;
        if (chk_en) begin
            got  = '{imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, trap, trap_cause};
            mask = '1;
            if (!exp_v.pc_we) mask.pc_sel = 1'b0;
            n_cmp++;
            if ((got & mask) !== (exp_v & mask)) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got %b expected %b (imem_req,ir_we,dmem_req,dmem_we,pc_we,pc_sel,rf_we,trap,cause)",
                         cyc_no, got & mask, exp_v & mask);
            end
`ifdef EXEC_SEQ_RETIRE_CNT_EN
            check("instret", longint'(instret), retired);
`endif
            if (ir_we)    begin n_ir++;  last_ir_cyc = cyc_no; end
            if (rf_we)    begin n_rf++;  last_rf_cyc = cyc_no; end
            if (dmem_req) n_dmem++;
            if (dmem_we)  n_dwe++;
            if (pc_we)    begin n_pcwe++; last_pcwe_cyc = cyc_no; last_pcsel = pc_sel; end
        end
    end

    task automatic cyc(input exp_t e, input logic iack, input logic dack);
        imem_ack = iack;
        dmem_ack = dack;
        exp_v    = e;
        chk_en   = 1'b1;
        @(posedge clock);
        #1;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        if (e.pc_we && !e.trap) retired++;
`endif
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        chk_en = 1'b0;
        reset = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        retired = 0;
`endif
    endtask

    task automatic set_flags(input int cls);
        s_load = 0; s_store = 0; s_jump = 0; s_branch = 0; s_csr = 0;
        alu_op = 4'($urandom_range(1, 15));
        funct3 = 3'($urandom_range(0, 7));
        case (cls)
            C_ALU:   opcode = 7'b0010011;
            C_CSR:   begin opcode = 7'b1110011; s_csr = 1; alu_op = 0; funct3 = 3'($urandom_range(1, 7)); end
            C_JUMP:  begin opcode = 7'b1101111; s_jump = 1; end
            C_BR:    begin opcode = 7'b1100011; s_branch = 1; end
            C_FENCE: begin opcode = 7'b0001111; alu_op = 0; end
            C_ENV:   begin opcode = 7'b1110011; alu_op = 0; funct3 = 3'd0; end
            C_LOAD:  begin opcode = 7'b0000011; s_load = 1; end
            C_STORE: begin opcode = 7'b0100011; s_store = 1; end
            default: begin
                alu_op = 0;
                case ($urandom_range(0, 3))
                    0: opcode = 7'h00;
                    1: opcode = 7'h7f;
                    2: opcode = 7'h0b;
                    default: begin opcode = 7'b1110011; funct3 = 3'($urandom_range(1, 7)); end
                endcase
            end
        endcase
    endtask

    task automatic halt_seq(input logic [1:0] cause);
        exp_t e;
        e = '0; e.trap = 1'b1; e.cause = cause;
        for (int i = 0; i < 3; i++) cyc(e, rbit(), rbit());
        do_reset();
    endtask

    // Expected timeline: a handshake may stall up to MAX_WAIT cycles; one more stall traps.
    task automatic run_instr(input int cls, input int fd, input int md, input logic taken);
        exp_t e;
        int   nwait;
        set_flags(cls);
        branch_taken = taken;
        nwait = (fd > MAX_WAIT) ? MAX_WAIT + 1 : fd;
        for (int i = 0; i < nwait; i++) begin
            e = '0; e.imem_req = 1; cyc(e, 1'b0, rbit());
        end
        if (fd > MAX_WAIT) begin halt_seq(2'd2); return; end
        e = '0; e.imem_req = 1; e.ir_we = 1; cyc(e, 1'b1, rbit());
        e = '0; cyc(e, rbit(), rbit());
        if (cls == C_ILL) begin halt_seq(2'd1); return; end
        e = '0;
        if (cls == C_BR) begin
            e.pc_we = 1; e.pc_sel = taken; cyc(e, rbit(), rbit()); return;
        end
        if (cls == C_FENCE || cls == C_ENV) begin
            e.pc_we = 1; cyc(e, rbit(), rbit()); return;
        end
        cyc(e, rbit(), rbit());
        if (cls == C_LOAD || cls == C_STORE) begin
            nwait = (md > MAX_WAIT) ? MAX_WAIT + 1 : md;
            for (int i = 0; i < nwait; i++) begin
                e = '0; e.dmem_req = 1; e.dmem_we = (cls == C_STORE); cyc(e, rbit(), 1'b0);
            end
            if (md > MAX_WAIT) begin halt_seq(2'd3); return; end
            e = '0; e.dmem_req = 1; e.dmem_we = (cls == C_STORE); e.pc_we = (cls == C_STORE);
            cyc(e, rbit(), 1'b1);
            if (cls == C_STORE) return;
        end
        e = '0; e.rf_we = 1; e.pc_we = 1; e.pc_sel = (cls == C_JUMP);
        cyc(e, rbit(), rbit());
    endtask

    initial begin
        int start, d_rf, d_dm, d_dw, d_pc, d_ir, cls, fd, md;
        exp_t e;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // ADDI x1,x0,5 with zero-wait ack
        start = cyc_no + 1; d_ir = n_ir; d_rf = n_rf; d_pc = n_pcwe;
        run_instr(C_ALU, 0, 0, 0);
        check("addi_ir_we_cycle", last_ir_cyc - start + 1, 1);
        check("addi_rf_we_cycle", last_rf_cyc - start + 1, 4);
        check("addi_pc_we_count", n_pcwe - d_pc, 1);
        check("addi_pc_sel", last_pcsel, 0);

        // LW with dmem_ack delayed 3 cycles
        start = cyc_no + 1; d_rf = n_rf; d_dm = n_dmem; d_dw = n_dwe;
        run_instr(C_LOAD, 0, 3, 0);
        check("lw_dmem_req_cycles", n_dmem - d_dm, 4);
        check("lw_dmem_we_cycles", n_dwe - d_dw, 0);
        check("lw_rf_we_count", n_rf - d_rf, 1);
        check("lw_total_cycles", last_rf_cyc - start + 1, 8);

        // BEQ taken then not taken
        for (int t = 1; t >= 0; t--) begin
            start = cyc_no + 1; d_rf = n_rf; d_pc = n_pcwe;
            run_instr(C_BR, 0, 0, 1'(t));
            check("beq_pc_we_count", n_pcwe - d_pc, 1);
            check("beq_pc_we_cycle", last_pcwe_cyc - start + 1, 3);
            check("beq_pc_sel", last_pcsel, t);
            check("beq_rf_we_count", n_rf - d_rf, 0);
        end

        // opcode 0x00 traps illegal; halt_seq checks trap and resets
        set_flags(C_ILL);
        start = n_ir;
        e = '0; e.imem_req = 1; e.ir_we = 1;
        opcode = 7'h00; alu_op = 0; funct3 = 0;
        cyc(e, 1'b1, 1'b0);
        e = '0; cyc(e, 1'b0, 1'b0);
        halt_seq(2'd1);
        check("ir_we_after_halt", n_ir - start, 1);

        // Timeout boundary on both handshakes
        run_instr(C_ALU, MAX_WAIT + 1, 0, 0);
        run_instr(C_ALU, MAX_WAIT, 0, 0);
        run_instr(C_STORE, 0, MAX_WAIT + 1, 0);
        run_instr(C_LOAD, 1, MAX_WAIT, 0);
        run_instr(C_JUMP, 2, 0, 0);
        run_instr(C_CSR, 0, 0, 0);
        run_instr(C_FENCE, 0, 0, 0);
        run_instr(C_ENV, 0, 0, 0);

        // Reset while SW is waiting in MEM; the next fetch must show no dmem_req
        set_flags(C_STORE);
        e = '0; e.imem_req = 1; e.ir_we = 1; cyc(e, 1'b1, 1'b0);
        e = '0; cyc(e, 1'b0, 1'b0);
        cyc(e, 1'b0, 1'b0);
        e = '0; e.dmem_req = 1; e.dmem_we = 1; cyc(e, 1'b0, 1'b0);
        d_pc = n_pcwe;
        chk_en = 1'b0;
        reset = 1'b1;
        dmem_ack = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        retired = 0;
`endif
        run_instr(C_ALU, 0, 0, 0);
        check("reset_mid_sw_pc_we", n_pcwe - d_pc, 1);

`ifdef EXEC_SEQ_RETIRE_CNT_EN
        do_reset();
        e = '0; e.imem_req = 1; cyc(e, 1'b0, 1'b0);
        check("instret_after_reset", longint'(instret), 0);
        for (int i = 0; i < 3; i++) run_instr(C_ALU, 0, 0, 0);
        check("instret_three_addi", longint'(instret), 3);
`endif

        // Random instruction stream
        for (int k = 0; k < 200; k++) begin
            cls = $urandom_range(0, 17);
            if (cls > 8) cls = cls - 9;
            fd = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
            md = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
            run_instr(cls, fd, md, rbit());
        end

        chk_en = 1'b0;
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
